enemy_deploy_scheduler: RTL and testbench

AI-side deploy scheduler for the enemy unit pool (nerd/and/or/not spawn slots). Runs an elixir budget, picks which idle unit slot to deploy with cost-gated round-robin, chooses the lane from tower HP and tower-destroyed status, and holds the slot's `on` request until the slot reports it is alive. It sits between the game-state logic (tower HP, tower-down flags) and the per-unit spawn modules. It replaces the unconditional `on` tie-offs on those modules.

---
 rtl/clash_pkg.sv | 37 +++
 rtl/rr_pick.sv | 30 +++
 rtl/enemy_deploy_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_enemy_deploy_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clash_pkg.sv
// Shared types and constants for the enemy deploy scheduler slice.
// Holds the FSM state encoding, lane constants and the lane-choice helper.
package clash_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_REQUEST  = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_COOLDOWN = 3'd4
  } sched_state_t;

  localparam logic       LANE_TOP   = 1'b0;
  localparam logic       LANE_BOT   = 1'b1;
  localparam logic [9:0] LANE_TOP_Y = 10'd80;
  localparam logic [9:0] LANE_BOT_Y = 10'd400;
  localparam logic [9:0] SPAWN_X    = 10'd250;
  localparam int         ELIXIR_W   = 4;

  // Push toward the healthier right tower's lane unless that lane's
  // tower is gone while the other still stands.
  function automatic logic lane_pick(
    input logic [5:0] hpr,
    input logic [5:0] hpl,
    input logic       towerrd,
    input logic       towerld
  );
    logic pref;
    logic pref_down;
    logic other_down;
    pref       = (hpr >= hpl) ? LANE_BOT : LANE_TOP;
    pref_down  = pref ? towerld : towerrd;
    other_down = pref ? towerrd : towerld;
    return (pref_down && !other_down) ? ~pref : pref;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of elig after last_grant.
// Ports: elig, last_grant in; grant index and valid out.
module rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          valid
);

  always_comb begin
    logic [GW:0] s;
    grant = '0;
    valid = 1'b0;
    s     = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = N; k >= 1; k--) begin
      s = {1'b0, last_grant} + (GW+1)'(k);
      if (s >= (GW+1)'(N))
        s = s - (GW+1)'(N);
      if (elig[s[GW-1:0]]) begin
        grant = s[GW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_deploy_scheduler.sv
// Enemy deploy scheduler: elixir budget, round-robin slot grant, lane choice.
// In: vga_clk, reset, vsync, game_active, slot_alive, slot_cost, hpr/hpl,
//     towerrd/towerld. Out: slot_on, lane, elixir, busy, timeout_err.
module enemy_deploy_scheduler
  import clash_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int ELIXIR_MAX      = 10,
  parameter int ELIXIR_INIT     = 5,
  parameter int ELIXIR_FRAMES   = 60,
  parameter int COOLDOWN_FRAMES = 120,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   game_active,
  input  logic [NUM_SLOTS-1:0]   slot_alive,
  input  logic [4*NUM_SLOTS-1:0] slot_cost,
  input  logic [5:0]             hpr,
  input  logic [5:0]             hpl,
  input  logic                   towerrd,
  input  logic                   towerld,
  output logic [NUM_SLOTS-1:0]   slot_on,
  output logic                   lane,
  output logic [ELIXIR_W-1:0]    elixir,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int EW = ELIXIR_W;
  localparam int GW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int FW = $clog2(ELIXIR_FRAMES + 1);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE     = S_IDLE;
  localparam logic [2:0] ST_SELECT   = S_SELECT;
  localparam logic [2:0] ST_REQUEST  = S_REQUEST;
  localparam logic [2:0] ST_WAIT_ACK = S_WAIT_ACK;
  localparam logic [2:0] ST_COOLDOWN = S_COOLDOWN;

  logic [2:0]           state;
  logic                 vsync_q;
  logic                 ftick;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        pick_g;
  logic                 pick_v;
  logic [NUM_SLOTS-1:0] elig;
  logic [3:0]           cost_g;
  logic [3:0]           cost_p;
  logic [FW-1:0]        fcnt;
  logic [CW-1:0]        cd_cnt;
  logic [TW-1:0]        to_cnt;
  logic                 inc;
  logic                 ded;
  logic                 ack;
  logic                 tmo;
  logic [EW:0]          e_sum;
  logic [EW-1:0]        elixir_nx;

  assign ftick = vsync & ~vsync_q;

  always_comb begin
    elig   = '0;
    cost_g = '0;
    cost_p = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      elig[i] = !slot_alive[i] &&
                ({1'b0, slot_cost[4*i +: 4]} <= 5'(elixir));
      if (GW'(i) == grant)
        cost_g = slot_cost[4*i +: 4];
      if (GW'(i) == pick_g)
        cost_p = slot_cost[4*i +: 4];
    end
  end

  rr_pick #(
    .N  (NUM_SLOTS),
    .GW (GW)
  ) u_rr_pick (
    .elig       (elig),
    .last_grant (last_grant),
    .grant      (pick_g),
    .valid      (pick_v)
  );

  assign ack = slot_alive[grant];
  assign inc = game_active && ftick &&
               (fcnt == FW'(ELIXIR_FRAMES - 1));
  assign ded = game_active && (state == ST_SELECT) && pick_v;
  assign tmo = game_active && (state == ST_WAIT_ACK) && !ack &&
               ftick && (to_cnt == TW'(ACK_TIMEOUT - 1));

  // Deduction only happens when cost <= elixir, so the 5-bit sum
  // never goes negative; only the upper clamp is needed.
  always_comb begin
    e_sum = {1'b0, elixir} + {{EW{1'b0}}, inc};
    if (ded)
      e_sum = e_sum - {1'b0, cost_p};
    if (tmo)
      e_sum = e_sum + {1'b0, cost_g};
    elixir_nx = (e_sum > (EW+1)'(ELIXIR_MAX)) ?
                EW'(ELIXIR_MAX) : e_sum[EW-1:0];
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      vsync_q     <= 1'b0;
      grant       <= '0;
      last_grant  <= GW'(NUM_SLOTS - 1);
      lane        <= LANE_TOP;
      elixir      <= EW'(ELIXIR_INIT);
      timeout_err <= 1'b0;
      fcnt        <= '0;
      cd_cnt      <= '0;
      to_cnt      <= '0;
    end else begin
      vsync_q <= vsync;
      elixir  <= elixir_nx;
      if (!game_active) begin
        state  <= ST_IDLE;
        fcnt   <= '0;
        cd_cnt <= '0;
        to_cnt <= '0;
      end else begin
        if (ftick)
          fcnt <= inc ? '0 : fcnt + 1'b1;
        unique case (state)
          ST_IDLE: begin
            if (ftick)
              state <= ST_SELECT;
          end
          ST_SELECT: begin
            if (pick_v) begin
              grant      <= pick_g;
              last_grant <= pick_g;
              lane       <= lane_pick(hpr, hpl, towerrd, towerld);
              state      <= ST_REQUEST;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_REQUEST: begin
            to_cnt <= '0;
            state  <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: begin
            if (ack) begin
              to_cnt <= '0;
              state  <= ST_COOLDOWN;
            end else if (tmo) begin
              to_cnt      <= '0;
              timeout_err <= 1'b1;
              state       <= ST_COOLDOWN;
            end else if (ftick) begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          ST_COOLDOWN: begin
            if (ftick) begin
              if (cd_cnt == CW'(COOLDOWN_FRAMES - 1)) begin
                cd_cnt <= '0;
                state  <= ST_IDLE;
              end else begin
                cd_cnt <= cd_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state == ST_REQUEST) || (state == ST_WAIT_ACK);

  // Request is a level derived from state, so it is one-hot or zero
  // by construction and drops the cycle the FSM leaves REQUEST/WAIT_ACK.
  always_comb begin
    slot_on = '0;
    if (busy)
      slot_on[grant] = 1'b1;
  end

endmodule

// File: tb/tb_enemy_deploy_scheduler.sv
// Directed bench for enemy_deploy_scheduler.
// Frames are vsync pulses; expected values are hand-derived per step.
module tb_enemy_deploy_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        game_active;
  logic [3:0]  slot_alive;
  logic [15:0] slot_cost;
  logic [5:0]  hpr;
  logic [5:0]  hpl;
  logic        towerrd;
  logic        towerld;
  logic [3:0]  slot_on;
  logic        lane;
  logic [3:0]  elixir;
  logic        busy;
  logic        timeout_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 vga_clk = ~vga_clk;

  enemy_deploy_scheduler dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .vsync       (vsync),
    .game_active (game_active),
    .slot_alive  (slot_alive),
    .slot_cost   (slot_cost),
    .hpr         (hpr),
    .hpl         (hpl),
    .towerrd     (towerrd),
    .towerld     (towerld),
    .slot_on     (slot_on),
    .lane        (lane),
    .elixir      (elixir),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One vsync rising edge -> exactly one ftick; 4 cycles per frame.
  task automatic frame();
    @(negedge vga_clk);
    vsync = 1'b1;
    @(negedge vga_clk);
    vsync = 1'b0;
    @(negedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++)
      frame();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge vga_clk);
    reset = 1'b0;
  endtask

  initial begin
    vsync       = 1'b0;
    game_active = 1'b1;
    slot_alive  = 4'b0000;
    slot_cost   = 16'h2543;
    hpr         = 6'd30;
    hpl         = 6'd30;
    towerrd     = 1'b0;
    towerld     = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge vga_clk);
    check("rst_slot_on", 16'(slot_on), 16'h0);
    check("rst_lane", 16'(lane), 16'h0);
    check("rst_elixir", 16'(elixir), 16'd5);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_tmo", 16'(timeout_err), 16'h0);
    reset = 1'b0;

    // Frame 1: slot 0 wins first, cost 3.
    frame();
    check("a_slot_on", 16'(slot_on), 16'b0001);
    check("a_busy", 16'(busy), 16'h1);
    check("a_elixir", 16'(elixir), 16'd2);
    check("a_lane", 16'(lane), 16'h1);
    frame();
    check("a_hold", 16'(slot_on), 16'b0001);
    slot_alive = 4'b0001;
    @(negedge vga_clk);
    check("a_ack_on", 16'(slot_on), 16'h0);
    check("a_ack_busy", 16'(busy), 16'h0);
    // Cooldown spans frames 3..122; elixir +1 at frames 60, 120.
    frames(119);
    check("cd_119_busy", 16'(busy), 16'h0);
    check("cd_elixir", 16'(elixir), 16'd4);
    frame();
    check("cd_120_busy", 16'(busy), 16'h0);
    frame();
    check("g1_slot_on", 16'(slot_on), 16'b0010);
    check("g1_elixir", 16'(elixir), 16'd0);
    check("g1_busy", 16'(busy), 16'h1);

    // Disable mid-WAIT_ACK: no refund of slot 1's cost.
    game_active = 1'b0;
    @(negedge vga_clk);
    check("ga_slot_on", 16'(slot_on), 16'h0);
    check("ga_busy", 16'(busy), 16'h0);
    check("ga_elixir", 16'(elixir), 16'd0);
    game_active = 1'b1;

    // Only slot 1 dead but unaffordable.
    slot_alive = 4'b1101;
    frame();
    check("ne_slot_on", 16'(slot_on), 16'h0);
    check("ne_busy", 16'(busy), 16'h0);

    // Timeout path: slot 2 (cost 5) never acks.
    slot_alive = 4'b1011;
    hpr        = 6'd20;
    hpl        = 6'd30;
    towerrd    = 1'b1;
    towerld    = 1'b0;
    do_reset();
    check("r2_elixir", 16'(elixir), 16'd5);
    frame();
    check("t_slot_on", 16'(slot_on), 16'b0100);
    check("t_lane", 16'(lane), 16'h1);
    check("t_elixir", 16'(elixir), 16'd0);
    frames(3);
    check("t_hold", 16'(slot_on), 16'b0100);
    check("t_err0", 16'(timeout_err), 16'h0);
    frame();
    check("t_drop", 16'(slot_on), 16'h0);
    check("t_err1", 16'(timeout_err), 16'h1);
    check("t_refund", 16'(elixir), 16'd5);
    check("t_busy", 16'(busy), 16'h0);

    // Grow to the cap: +1 at frames 60..300, saturate at 360.
    slot_alive = 4'b1111;
    frames(354);
    check("cap_359", 16'(elixir), 16'd10);
    frame();
    check("cap_360", 16'(elixir), 16'd10);
    frames(55);

    // Frame 416 grants slot 2 (cost 1), both towers down -> top lane.
    slot_cost  = 16'h2143;
    slot_alive = 4'b1011;
    towerld    = 1'b1;
    frame();
    check("c_slot_on", 16'(slot_on), 16'b0100);
    check("c_lane", 16'(lane), 16'h0);
    check("c_elixir", 16'(elixir), 16'd9);
    frames(3);
    check("c_hold", 16'(slot_on), 16'b0100);
    check("c_elixir2", 16'(elixir), 16'd9);
    // Frame 420: timeout refund coincides with +1 -> 11 clamps to 10.
    frame();
    check("c_clamp", 16'(elixir), 16'd10);
    check("c_drop", 16'(slot_on), 16'h0);
    check("c_busy", 16'(busy), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
